// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the CPU data-memory responder:
//   - access size encodings carried on mem_size
//   - controller state enumeration
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;   // 2'b11 is reserved and handled as a word

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } mem_state_t;

endpackage

// File: rtl/data_lane_align.sv
// ---------------------------------------------------------------------------
// data_lane_align
// Combinational lane steering for little-endian byte/half/word accesses.
//   size        in   access size (MEM_BYTE / MEM_HALF / MEM_WORD, 11 = word)
//   addr_lo     in   byte offset within the word (address bits [1:0])
//   sign        in   1 = sign-extend loads, 0 = zero-extend
//   wdata       in   right-justified store data
//   rword       in   full 32-bit word read from the array
//   wmask       out  byte-lane write enables
//   wdata_lane  out  store data replicated into every lane
//   rdata_ext   out  selected load lane, extended to 32 bits
//   misaligned  out  half on odd address or word on non-zero offset
// ---------------------------------------------------------------------------
module data_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        wmask      = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rword;
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: begin
                // Replicating the byte into every lane lets the mask alone pick the target.
                wmask      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign & rbyte[7]}}, rbyte};
            end
            MEM_HALF: begin
                misaligned = addr_lo[0];
                wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign & rhalf[15]}}, rhalf};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
                wmask      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Data-memory responder for the pipelined core: wait-state FSM, request
// latch, and the 2**ADDR_WIDTH x 32 storage array.
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   data_ram_ena  in   request valid (held while mem_stall=1)
//   data_ram_wea  in   1 = store, 0 = load
//   mem_addr      in   byte address (upper bits wrap)
//   mem_wdata     in   right-justified store data
//   mem_size      in   00 byte, 01 half, 10/11 word
//   mem_sign      in   load sign-extension select
//   mem_rdata     out  registered load result
//   mem_stall     out  core must hold its request
//   adel / ades   out  one-cycle misaligned load / store pulses
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_ena,
    input  logic        data_ram_wea,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    mem_state_t state;
    logic [3:0] cnt;

    logic                  lat_wea;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [1:0]            lat_size;
    logic                  lat_sign;

    logic                  cur_wea;
    logic [ADDR_WIDTH+1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [1:0]            cur_size;
    logic                  cur_sign;
    logic                  do_access;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rword;
    logic [3:0]            wmask;
    logic [31:0]           wdata_lane;
    logic [31:0]           rdata_ext;
    logic                  misaligned;

    logic [31:0] mem_array [2**ADDR_WIDTH];

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

    // Zero-wait accesses use the live request; delayed ones use the latched copy.
    always_comb begin
        if (state == IDLE) begin
            cur_wea   = data_ram_wea;
            cur_addr  = mem_addr[ADDR_WIDTH+1:0];
            cur_wdata = mem_wdata;
            cur_size  = mem_size;
            cur_sign  = mem_sign;
        end else begin
            cur_wea   = lat_wea;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_size  = lat_size;
            cur_sign  = lat_sign;
        end
    end

    assign do_access = ((state == IDLE) && data_ram_ena && (WAIT_CYCLES == 0))
                     || (state == ACCESS);

    // Gated by rst so a held request never shows as a stall while in reset.
    assign mem_stall = !rst && (((state == IDLE) && data_ram_ena && (WAIT_CYCLES != 0))
                                || (state == WAIT));

    assign word_idx = cur_addr[ADDR_WIDTH+1:2];
    assign rword    = mem_array[word_idx];

    data_lane_align u_align (
        .size       (cur_size),
        .addr_lo    (cur_addr[1:0]),
        .sign       (cur_sign),
        .wdata      (cur_wdata),
        .rword      (rword),
        .wmask      (wmask),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    // Storage array is not reset; writes are suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (do_access && !rst && cur_wea && !misaligned) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem_array[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_rdata <= '0;
            adel      <= 1'b0;
            ades      <= 1'b0;
            lat_wea   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= MEM_BYTE;
            lat_sign  <= 1'b0;
        end else begin
            adel <= 1'b0;
            ades <= 1'b0;

            if (do_access) begin
                if (misaligned) begin
                    adel <= !cur_wea;
                    ades <= cur_wea;
                end else if (!cur_wea) begin
                    mem_rdata <= rdata_ext;
                end
            end

            case (state)
                IDLE: begin
                    if (data_ram_ena && (WAIT_CYCLES != 0)) begin
                        lat_wea   <= data_ram_wea;
                        lat_addr  <= mem_addr[ADDR_WIDTH+1:0];
                        lat_wdata <= mem_wdata;
                        lat_size  <= mem_size;
                        lat_sign  <= mem_sign;
                        if (WAIT_CYCLES == 1) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The request still visible here is the one just served.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Responder for the CPU core's data-memory port: accepts load/store requests (ena/wea/address/write data plus access size), performs byte/halfword/word lane alignment and sign/zero extension, and owns the data storage array. It sits between the pipelined MIPS core and the data storage. It models a configurable number of wait states, back-pressuring the core with a stall signal. It also flags misaligned loads and stores for the core's exception logic.

## Interface
- ADDR_WIDTH, 10, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, extra cycles before an access completes; legal range 0..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- data_ram_ena  in  1  request valid; held stable by the core while mem_stall=1.
- data_ram_wea  in  1  1 = store, 0 = load.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_sign  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- mem_rdata  out  32  load result, extended to 32 bits.
- mem_stall  out  1  core must hold its request and freeze.
- adel  out  1  one-cycle pulse: misaligned load.
- ades  out  1  one-cycle pulse: misaligned store.

## Operation
- Word index = mem_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Misaligned accesses: half with addr[0]=1, or word with addr[1:0]!=0.
  - No array access; no write.
  - mem_rdata holds its previous value.
  - adel or ades pulses in the cycle the result would otherwise be valid.
- Store lanes (little-endian):
  - Byte at addr[1:0]=k writes bits [8k+7:8k] from wdata[7:0].
  - Half at addr[1]=h writes bits [16h+15:16h] from wdata[15:0].
  - Word writes all 32 bits.
  - Other bytes of the word are untouched.
- Load: select the same lane, then extend per mem_sign. Word loads ignore mem_sign.
- Stores do not change mem_rdata.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE with ena=1, WAIT_CYCLES=0: access at this edge; stay IDLE.
  - IDLE with ena=1, WAIT_CYCLES=1: latch the request; go to ACCESS.
  - IDLE with ena=1, WAIT_CYCLES>1: latch the request; go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT: decrement cnt; go to ACCESS when cnt==1.
  - ACCESS: perform the access using the latched fields; go to IDLE. A request visible in the ACCESS cycle is the same held request and is not re-accepted.
- mem_stall = (IDLE & ena & WAIT_CYCLES>0) | WAIT.
- Reset values: mem_rdata=0, mem_stall=0, adel=0, ades=0, state=IDLE, cnt=0. Array contents are not reset.
- Reset during WAIT or ACCESS: the request is dropped, with no write and no pulse.

## Timing
- Request first presented in cycle T, with N = WAIT_CYCLES.
  - mem_stall is high in cycles T..T+N-1 (exactly N cycles; combinational in T, registered afterwards).
  - The array access occurs at the end of cycle T+N.
  - Load data is valid on mem_rdata from T+N+1 and is held until the next completed aligned load.
  - adel/ades are high only in cycle T+N+1.
- For N=0 there is no stall, and data is valid at T+1 (synchronous RAM behaviour).
- Back-to-back requests:
  - N=0: one request per cycle; a load following a store to the same word in cycle T+1 returns the new data.
  - N>0: a new request is accepted in T+N+1 at the earliest.

## Structure
- Shared package mem_pkg holds:
  - size encodings MEM_BYTE, MEM_HALF, MEM_WORD;
  - the state enum {IDLE, WAIT, ACCESS}.
- Sub-module data_lane_align (combinational) provides:
  - store: byte-lane write mask and shifted write data;
  - load: lane extract and sign/zero extension;
  - misalignment detect.
- The top of this block holds the FSM, the request latch, and the storage array.

## Test plan
- N=0; store word 0xDEADBEEF to 0x10, then load word 0x10 in the next cycle → mem_rdata=0xDEADBEEF at T+2; mem_stall never high.
- N=0; store byte 0x80 to 0x13 over word 0x00000000; load byte signed at 0x13 → 0xFFFFFF80; unsigned → 0x00000080; load word 0x10 → 0x80000000.
- N=3; load request at T → mem_stall high T..T+2, low at T+3; rdata valid at T+4; held ena during the stall is not re-accepted (exactly one access).
- Load half at 0x21 → adel pulse at T+1, mem_rdata unchanged. Store word at 0x22 → ades pulse; array unchanged.
- Address wrap: ADDR_WIDTH=10, store to 0x1000 → load from 0x0 returns the same data.
- N=4; assert rst in the WAIT state of a store → mem_stall=0 immediately, state IDLE, target word unchanged.
